// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 hex keypad scanner.
// Latency: none (package only).
// Backpressure: none (package only).
package keypad_pkg;

    // Scanner FSM states
    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HOLD     = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    // Hex code per key, indexed by {row_index, col_index}
    localparam logic [3:0] KEYMAP [16] = '{
        4'h1, 4'h2, 4'h3, 4'hA,
        4'h4, 4'h5, 4'h6, 4'hB,
        4'h7, 4'h8, 4'h9, 4'hC,
        4'h0, 4'hF, 4'hE, 4'hD
    };

    // Code of the key that clears the entry register when the clear option is built in
    localparam logic [3:0] CLEAR_CODE = 4'hF;

    // Active-low column drive patterns, indexed by column number
    localparam logic [3:0] COL_PAT [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    // Row value with no key pressed (pull-ups)
    localparam logic [3:0] ROWS_IDLE = 4'b1111;

    // True when exactly one row is pulled low
    function automatic logic single_row_low(input logic [3:0] r);
        logic res;
        case (r)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: res = 1'b1;
            default:                            res = 1'b0;
        endcase
        return res;
    endfunction

    // Row number of a single-low row pattern
    function automatic logic [1:0] row_index(input logic [3:0] r);
        logic [1:0] idx;
        case (r)
            4'b1110: idx = 2'd0;
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/keypad_sync.sv
// Two-flop synchroniser for the asynchronous keypad row inputs.
// Latency: 2 clocks from d to q.
// Backpressure: none; samples every clock.
module keypad_sync (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] d,
    output logic [3:0] q
);

    logic [3:0] meta;

    // Two-stage capture; reset to idle (all rows high) so no phantom key appears
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 4'b1111;
            q    <= 4'b1111;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 hex keypad scanner: column rotation, press/release debounce, key strobe, 16-bit entry register.
// Latency: strobe one clock after the DEBOUNCE_SCANS-th matching scan tick; num updates one clock after the strobe.
// Backpressure: none; strobes are fire-and-forget. Optional macro KEYPAD_CLEAR_EN makes key F clear num.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV_BITS  = 16,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  row,
    output logic [3:0]  col,
    output logic [3:0]  key_code,
    output logic        key_valid,
    output logic [15:0] num
);

    localparam logic [3:0] DEB_N = DEBOUNCE_SCANS[3:0];

    logic [SCAN_DIV_BITS-1:0] div;
    logic                     tick;
    logic [3:0]               rs;

    state_t     state, state_nx;
    logic [1:0] col_idx, col_idx_nx;
    logic [3:0] cnt, cnt_nx, cnt_inc;
    logic [3:0] pat, pat_nx;
    logic       kv_nx;
    logic [3:0] code_nx;
    logic [15:0] num_nx;

    keypad_sync u_sync (
        .clk (clk),
        .rst (rst),
        .d   (row),
        .q   (rs)
    );

    // Free-running scan divider; tick is an enable pulse when the counter is all-ones
    always_ff @(posedge clk) begin
        if (rst) begin
            div <= '0;
        end else begin
            div <= div + 1'b1;
        end
    end

    assign tick    = &div;
    assign cnt_inc = cnt + 4'd1;
    assign col     = COL_PAT[col_idx];

    // FSM state and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= SCAN;
            col_idx   <= 2'd0;
            cnt       <= 4'd0;
            pat       <= ROWS_IDLE;
            key_valid <= 1'b0;
            key_code  <= 4'h0;
        end else begin
            state     <= state_nx;
            col_idx   <= col_idx_nx;
            cnt       <= cnt_nx;
            pat       <= pat_nx;
            key_valid <= kv_nx;
            key_code  <= code_nx;
        end
    end

    // Next-state logic: all decisions are taken on scan ticks only
    always_comb begin
        state_nx   = state;
        col_idx_nx = col_idx;
        cnt_nx     = cnt;
        pat_nx     = pat;
        kv_nx      = 1'b0;
        code_nx    = key_code;
        if (tick) begin
            case (state)
                SCAN: begin
                    // Ghost patterns (several rows low) are treated as no key
                    if (single_row_low(rs)) begin
                        pat_nx   = rs;
                        cnt_nx   = 4'd1;
                        state_nx = DEBOUNCE;
                    end else begin
                        col_idx_nx = col_idx + 2'd1;
                    end
                end
                DEBOUNCE: begin
                    if (rs == pat) begin
                        cnt_nx = cnt_inc;
                        if (cnt_inc >= DEB_N) begin
                            kv_nx    = 1'b1;
                            code_nx  = KEYMAP[{row_index(pat), col_idx}];
                            state_nx = HOLD;
                        end
                    end else begin
                        state_nx   = SCAN;
                        col_idx_nx = col_idx + 2'd1;
                    end
                end
                HOLD: begin
                    // Column stays put; other keys are ignored until full release
                    if (rs == ROWS_IDLE) begin
                        cnt_nx   = 4'd1;
                        state_nx = RELEASE;
                    end
                end
                RELEASE: begin
                    if (rs == ROWS_IDLE) begin
                        cnt_nx = cnt_inc;
                        if (cnt_inc >= DEB_N) begin
                            state_nx   = SCAN;
                            col_idx_nx = col_idx + 2'd1;
                        end
                    end else begin
                        state_nx = HOLD;
                    end
                end
                default: begin
                    state_nx = SCAN;
                end
            endcase
        end
    end

    // Entry register update on each accepted key
    always_comb begin
        num_nx = num;
        if (key_valid) begin
`ifdef KEYPAD_CLEAR_EN
            if (key_code == CLEAR_CODE) begin
                num_nx = 16'h0000;
            end else begin
                num_nx = {num[11:0], key_code};
            end
`else
            num_nx = {num[11:0], key_code};
`endif
        end
    end

    // Entry register
    always_ff @(posedge clk) begin
        if (rst) begin
            num <= 16'h0000;
        end else begin
            num <= num_nx;
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed self-checking bench for keypad_scanner with a small keypad matrix model.
// Runs with a 4-clock scan tick and 3-sample debounce.
// Inputs driven just after the falling edge; outputs sampled there too.
module tb_keypad_scanner;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [3:0]  key_code;
    logic        key_valid;
    logic [15:0] num;

    int          tests = 0;
    int          fails = 0;
    logic [15:0] key_mask = 16'h0000;
    logic [1:0]  tb_div = 2'd0;
    int          strobe_cnt = 0;
    int          dbl_cnt = 0;
    logic        prev_kv = 1'b0;

    always #5 clk = ~clk;

    keypad_scanner #(
        .SCAN_DIV_BITS  (2),
        .DEBOUNCE_SCANS (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .row       (row),
        .col       (col),
        .key_code  (key_code),
        .key_valid (key_valid),
        .num       (num)
    );

    // Keypad matrix: a pressed key pulls its row low while its column is driven low
    always_comb begin
        row = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (!col[c] && key_mask[r*4+c]) row[r] = 1'b0;
            end
        end
    end

    // Reference tick phase: tick edge is the posedge that returns this to zero
    always @(posedge clk) begin
        if (rst) tb_div <= 2'd0;
        else     tb_div <= tb_div + 2'd1;
    end

    // Strobe monitor
    always @(negedge clk) begin
        if (key_valid) strobe_cnt = strobe_cnt + 1;
        if (key_valid && prev_kv) dbl_cnt = dbl_cnt + 1;
        prev_kv = key_valid;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic next_tick();
        @(negedge clk);
        while (tb_div != 2'd0) @(negedge clk);
        #1;
    endtask

    task automatic clk1();
        @(negedge clk);
        #1;
    endtask

    // Press key idx, wait for its strobe, capture code and resulting num, then release fully
    task automatic press_release(input int idx, output bit found,
                                 output logic [3:0] code, output logic [15:0] n);
        found = 1'b0;
        code  = 4'hx;
        key_mask[idx] = 1'b1;
        for (int i = 0; i < 16; i++) begin
            next_tick();
            if (key_valid) begin
                found = 1'b1;
                break;
            end
        end
        code = key_code;
        clk1();
        n = num;
        key_mask = 16'h0000;
        repeat (4) next_tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) clk1();
        tests++; if (col !== 4'b1110) begin fails++; $display("FAIL reset_col: got %b want 1110", col); end
        tests++; if (key_valid !== 1'b0) begin fails++; $display("FAIL reset_kv: got %b want 0", key_valid); end
        tests++; if (num !== 16'h0000) begin fails++; $display("FAIL reset_num: got %h want 0000", num); end
        tests++; if (key_code !== 4'h0) begin fails++; $display("FAIL reset_code: got %h want 0", key_code); end
        rst = 1'b0;
    endtask

    task automatic test_idle_scan();
        logic [3:0] exp_col [5];
        exp_col = '{4'b1101, 4'b1011, 4'b0111, 4'b1110, 4'b1101};
        for (int i = 0; i < 5; i++) begin
            next_tick();
            tests++;
            if (col !== exp_col[i]) begin
                fails++; $display("FAIL idle_col[%0d]: got %b want %b", i, col, exp_col[i]);
            end
        end
        tests++; if (strobe_cnt != 0) begin fails++; $display("FAIL idle_strobes: got %0d want 0", strobe_cnt); end
        tests++; if (num !== 16'h0000) begin fails++; $display("FAIL idle_num: got %h want 0000", num); end
    endtask

    task automatic test_single_key();
        int j = -1;
        int kv_at = -1;
        int base;
        base = strobe_cnt;
        key_mask[5] = 1'b1;
        if (col == 4'b1101) j = 0;
        for (int i = 1; i <= 16; i++) begin
            next_tick();
            if (j < 0 && col == 4'b1101) j = i;
            if (key_valid) begin
                kv_at = i;
                break;
            end
        end
        tests++; if (j < 0 || kv_at != j + 3) begin fails++; $display("FAIL key5_latency: strobe tick %0d want %0d", kv_at, j + 3); end
        tests++; if (key_code !== 4'h5) begin fails++; $display("FAIL key5_code: got %h want 5", key_code); end
        clk1();
        tests++; if (num !== 16'h0005) begin fails++; $display("FAIL key5_num: got %h want 0005", num); end
        repeat (6) next_tick();
        tests++; if (strobe_cnt != base + 1) begin fails++; $display("FAIL key5_one_strobe: got %0d want %0d", strobe_cnt - base, 1); end
        tests++; if (col !== 4'b1101) begin fails++; $display("FAIL key5_hold_col: got %b want 1101", col); end
        key_mask = 16'h0000;
        next_tick();
        next_tick();
        tests++; if (col !== 4'b1101) begin fails++; $display("FAIL key5_release2_col: got %b want 1101", col); end
        next_tick();
        tests++; if (col !== 4'b1011) begin fails++; $display("FAIL key5_release3_col: got %b want 1011", col); end
    endtask

    task automatic test_sequence();
        int          keys [5];
        logic [3:0]  codes [5];
        logic [15:0] nums [5];
        bit          found;
        logic [3:0]  code;
        logic [15:0] n;
        keys  = '{0, 1, 2, 3, 4};
        codes = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4};
        nums  = '{16'h0051, 16'h0512, 16'h5123, 16'h123A, 16'h23A4};
        for (int k = 0; k < 5; k++) begin
            press_release(keys[k], found, code, n);
            tests++;
            if (!found || code !== codes[k]) begin
                fails++; $display("FAIL seq_code[%0d]: got %h (found %0d) want %h", k, code, found, codes[k]);
            end
            tests++;
            if (n !== nums[k]) begin
                fails++; $display("FAIL seq_num[%0d]: got %h want %h", k, n, nums[k]);
            end
        end
    endtask

    task automatic test_bounce();
        int base;
        int kv_at = -1;
        bit aligned = 1'b0;
        for (int i = 0; i < 8; i++) begin
            next_tick();
            if (col == 4'b1110) begin
                aligned = 1'b1;
                break;
            end
        end
        tests++; if (!aligned) begin fails++; $display("FAIL bounce_align: col %b never reached 1110", col); end
        base = strobe_cnt;
        key_mask[4] = 1'b1;
        next_tick();
        next_tick();
        key_mask = 16'h0000;
        next_tick();
        tests++; if (col !== 4'b1101) begin fails++; $display("FAIL bounce_abort_col: got %b want 1101", col); end
        tests++; if (strobe_cnt != base) begin fails++; $display("FAIL bounce_no_strobe: got %0d want 0", strobe_cnt - base); end
        key_mask[4] = 1'b1;
        for (int i = 4; i <= 14; i++) begin
            next_tick();
            if (key_valid) begin
                kv_at = i;
                break;
            end
        end
        tests++; if (kv_at != 9) begin fails++; $display("FAIL bounce_latency: strobe tick %0d want 9", kv_at); end
        tests++; if (key_code !== 4'h4) begin fails++; $display("FAIL bounce_code: got %h want 4", key_code); end
        clk1();
        tests++; if (num !== 16'h3A44) begin fails++; $display("FAIL bounce_num: got %h want 3A44", num); end
        key_mask = 16'h0000;
        repeat (4) next_tick();
    endtask

    task automatic test_ghost();
        int base;
        logic [3:0] prev;
        base = strobe_cnt;
        key_mask[0] = 1'b1;
        key_mask[8] = 1'b1;
        prev = col;
        for (int i = 0; i < 8; i++) begin
            next_tick();
            tests++;
            if (col !== {prev[2:0], prev[3]}) begin
                fails++; $display("FAIL ghost_col[%0d]: got %b want %b", i, col, {prev[2:0], prev[3]});
            end
            prev = col;
        end
        tests++; if (strobe_cnt != base) begin fails++; $display("FAIL ghost_strobe: got %0d want 0", strobe_cnt - base); end
        key_mask = 16'h0000;
        next_tick();
    endtask

    task automatic test_reset_hold();
        int base;
        int kv_at = -1;
        bit found = 1'b0;
        key_mask[10] = 1'b1;
        for (int i = 0; i < 16; i++) begin
            next_tick();
            if (key_valid) begin
                found = 1'b1;
                break;
            end
        end
        tests++; if (!found) begin fails++; $display("FAIL rsthold_first: no strobe for key 9"); end
        next_tick();
        next_tick();
        base = strobe_cnt;
        rst = 1'b1;
        clk1();
        clk1();
        tests++; if (col !== 4'b1110) begin fails++; $display("FAIL rsthold_col: got %b want 1110", col); end
        tests++; if (num !== 16'h0000) begin fails++; $display("FAIL rsthold_num: got %h want 0000", num); end
        tests++; if (key_valid !== 1'b0) begin fails++; $display("FAIL rsthold_kv: got %b want 0", key_valid); end
        rst = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            next_tick();
            if (key_valid) begin
                kv_at = i;
                break;
            end
        end
        tests++; if (kv_at != 5) begin fails++; $display("FAIL rsthold_latency: strobe tick %0d want 5", kv_at); end
        tests++; if (strobe_cnt != base + 1) begin fails++; $display("FAIL rsthold_strobes: got %0d want 1", strobe_cnt - base); end
        tests++; if (key_code !== 4'h9) begin fails++; $display("FAIL rsthold_code: got %h want 9", key_code); end
        clk1();
        tests++; if (num !== 16'h0009) begin fails++; $display("FAIL rsthold_num_after: got %h want 0009", num); end
        key_mask = 16'h0000;
        repeat (4) next_tick();
    endtask

    task automatic test_clear_key();
        int          keys [4];
        bit          found;
        logic [3:0]  code;
        logic [15:0] n;
        logic [15:0] exp_f;
        keys = '{0, 1, 2, 4};
        for (int k = 0; k < 4; k++) press_release(keys[k], found, code, n);
        tests++; if (n !== 16'h1234) begin fails++; $display("FAIL clear_pre_num: got %h want 1234", n); end
`ifdef KEYPAD_CLEAR_EN
        exp_f = 16'h0000;
`else
        exp_f = 16'h234F;
`endif
        press_release(13, found, code, n);
        tests++; if (!found || code !== 4'hF) begin fails++; $display("FAIL clear_code: got %h (found %0d) want F", code, found); end
        tests++; if (n !== exp_f) begin fails++; $display("FAIL clear_num: got %h want %h", n, exp_f); end
    endtask

    task automatic test_back_to_back();
        tests++; if (dbl_cnt != 0) begin fails++; $display("FAIL strobe_spacing: %0d back-to-back strobes want 0", dbl_cnt); end
    endtask

    initial begin
        test_reset();
        test_idle_scan();
        test_single_key();
        test_sequence();
        test_bounce();
        test_ghost();
        test_reset_hold();
        test_clear_key();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
